// File: rtl/sram_rn_w1_init_pkg.sv
// Shared types and helpers for the self-initialising multi-read SRAM.
// Holds the sweep FSM state type and the lane-to-bit mask expander.
package sram_pkg;

   typedef enum logic {
      SRAM_INIT,
      SRAM_RUN
   } sram_state_t;

   localparam int MAX_W = 1024;

   function automatic logic [MAX_W-1:0] expand_mask(
      input logic [MAX_W-1:0] mask,
      input int               gran
   );
      logic [MAX_W-1:0] r;
      r = '0;
      for (int b = 0; b < MAX_W; b++) begin
         r[b] = mask[b/gran];
      end
      return r;
   endfunction

endpackage

// File: rtl/sram_rn_w1_init_seq.sv
// Post-reset init sweep: walks every entry once, then parks in RUN.
// ready is registered and rises the cycle after the last entry is written.
import sram_pkg::*;

module sram_init_seq #(
   parameter int DEPTH    = 64,
   parameter int LG_DEPTH = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                init_we,
   output logic [LG_DEPTH-1:0] init_addr,
   output logic                ready
);

   localparam logic [LG_DEPTH-1:0] LAST = LG_DEPTH'(DEPTH - 1);

   sram_state_t         state;
   logic [LG_DEPTH-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SRAM_INIT;
         cnt   <= '0;
         ready <= 1'b0;
      end else begin
         unique case (state)
            SRAM_INIT: begin
               if (cnt == LAST) begin
                  state <= SRAM_RUN;
                  ready <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SRAM_RUN: begin
               state <= SRAM_RUN;
               ready <= 1'b1;
            end
            default: begin
               state <= SRAM_INIT;
               ready <= 1'b0;
            end
         endcase
      end
   end

   assign init_we   = (state == SRAM_INIT);
   assign init_addr = cnt;

endmodule

// File: rtl/sram_rn_w1_init.sv
// Byte-masked single-write, multi-read RAM with registered reads and
// a self-clearing init sweep; io_ready gates all user traffic.
import sram_pkg::*;

module sram_rn_w1_init #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 64,
   parameter int               LG_DEPTH  = 6,
   parameter int               NUM_READ  = 2,
   parameter int               MASK_GRAN = 8,
   parameter logic [WIDTH-1:0] INIT_VAL  = '0,
   parameter int               BYPASS    = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [WIDTH-1:0]             io_dinW_0,
   input  logic [WIDTH/MASK_GRAN-1:0]   io_maskW_0,
   input  logic [LG_DEPTH-1:0]          io_addrW_0,
   input  logic                         io_weW_0,
   input  logic [NUM_READ-1:0]          io_enR,
   input  logic [NUM_READ*LG_DEPTH-1:0] io_addrR,
   output logic [NUM_READ*WIDTH-1:0]    io_doutR,
   output logic [NUM_READ-1:0]          io_validR,
   output logic                         io_ready
);

   if (WIDTH % MASK_GRAN != 0) begin : g_chk_gran
      $error("WIDTH must be a multiple of MASK_GRAN");
   end
   if (DEPTH > 2**LG_DEPTH || DEPTH < 1) begin : g_chk_depth
      $error("DEPTH must be in 1..2**LG_DEPTH");
   end
   if (NUM_READ < 1) begin : g_chk_nread
      $error("NUM_READ must be at least 1");
   end
   if (WIDTH > MAX_W) begin : g_chk_width
      $error("WIDTH exceeds MAX_W");
   end

   localparam logic [LG_DEPTH:0] DEPTH_L = (LG_DEPTH+1)'(DEPTH);

   logic [WIDTH-1:0]    mem [DEPTH];
   logic                init_we;
   logic [LG_DEPTH-1:0] init_addr;
   logic                ready;
   logic [WIDTH-1:0]    wmask;
   logic                user_we;

   sram_init_seq #(
      .DEPTH    (DEPTH),
      .LG_DEPTH (LG_DEPTH)
   ) u_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_we   (init_we),
      .init_addr (init_addr),
      .ready     (ready)
   );

   assign io_ready = ready;

   assign wmask = WIDTH'(expand_mask(MAX_W'(io_maskW_0), MASK_GRAN));

   // Out-of-range addresses never touch the array.
   assign user_we = ready & io_weW_0
                  & ({1'b0, io_addrW_0} < DEPTH_L);

   always_ff @(posedge clk) begin
      if (init_we) begin
         mem[init_addr] <= INIT_VAL;
      end else if (user_we) begin
         mem[io_addrW_0] <= (mem[io_addrW_0] & ~wmask)
                          | (io_dinW_0 & wmask);
      end
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      logic [LG_DEPTH-1:0] ra;
      logic                in_rng;
      logic                hit;
      logic [WIDTH-1:0]    arr;
      logic [WIDTH-1:0]    rdata;
      logic [WIDTH-1:0]    dout_q;
      logic                valid_q;
      logic                take;

      assign ra     = io_addrR[i*LG_DEPTH +: LG_DEPTH];
      assign in_rng = ({1'b0, ra} < DEPTH_L);
      assign hit    = (BYPASS != 0) && user_we
                    && (io_addrW_0 == ra);
      assign take   = ready & io_enR[i];

      always_comb begin
         arr = INIT_VAL;
         if (in_rng) begin
            arr = mem[ra];
         end
         rdata = arr;
         if (hit) begin
            rdata = (arr & ~wmask) | (io_dinW_0 & wmask);
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dout_q  <= INIT_VAL;
            valid_q <= 1'b0;
         end else begin
            valid_q <= take;
            if (take) begin
               dout_q <= rdata;
            end
         end
      end

      assign io_doutR[i*WIDTH +: WIDTH] = dout_q;
      assign io_validR[i]               = valid_q;
   end

endmodule

// File: tb/tb_sram_rn_w1_init.sv
// Bench for sram_rn_w1_init: default instance plus a DEPTH=48, no-bypass
// instance sharing stimulus, checked against a model-fed scoreboard.
module tb_sram_rn_w1_init;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] din;
   logic [3:0]  mask;
   logic [5:0]  waddr;
   logic        we;
   logic [1:0]  en;
   logic [11:0] raddr;
   logic [63:0] dout_a, dout_b;
   logic [1:0]  val_a, val_b;
   logic        rdy_a, rdy_b;

   always #5 clk = ~clk;

   sram_rn_w1_init dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .io_dinW_0  (din),
      .io_maskW_0 (mask),
      .io_addrW_0 (waddr),
      .io_weW_0   (we),
      .io_enR     (en),
      .io_addrR   (raddr),
      .io_doutR   (dout_a),
      .io_validR  (val_a),
      .io_ready   (rdy_a)
   );

   sram_rn_w1_init #(
      .DEPTH  (48),
      .BYPASS (0)
   ) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .io_dinW_0  (din),
      .io_maskW_0 (mask),
      .io_addrW_0 (waddr),
      .io_weW_0   (we),
      .io_enR     (en),
      .io_addrR   (raddr),
      .io_doutR   (dout_b),
      .io_validR  (val_b),
      .io_ready   (rdy_b)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]  v;
      logic [31:0] d0;
      logic [31:0] d1;
   } exp_t;

   typedef struct {
      logic        w;
      logic [5:0]  wa;
      logic [31:0] d;
      logic [3:0]  m;
      logic [1:0]  e;
      logic [5:0]  r0;
      logic [5:0]  r1;
      logic [1:0]  xv;
      logic [31:0] x0;
      logic [31:0] x1;
   } vec_t;

   exp_t        qa[$];
   exp_t        qb[$];
   logic [31:0] ma [64];
   logic [31:0] mb [64];
   logic [31:0] la [2];
   logic [31:0] lb [2];
   vec_t        tbl [12];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      we    = 1'b0;
      din   = '0;
      mask  = '0;
      waddr = '0;
      en    = '0;
      raddr = '0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 64; i++) begin
         ma[i] = '0;
         mb[i] = '0;
      end
      for (int p = 0; p < 2; p++) begin
         la[p] = '0;
         lb[p] = '0;
      end
   endtask

   // One RUN-mode cycle: drive, push expectations, clock, pop and compare.
   task automatic op(input logic w, input logic [5:0] wa,
                     input logic [31:0] d, input logic [3:0] m,
                     input logic [1:0] e, input logic [5:0] r0,
                     input logic [5:0] r1);
      logic [31:0] bm;
      logic [31:0] merged;
      logic [5:0]  ra;
      logic [31:0] da, db;
      exp_t        ea, eb, ga, gb;
      we    = w;
      waddr = wa;
      din   = d;
      mask  = m;
      en    = e;
      raddr = {r1, r0};
      for (int b = 0; b < 4; b++) bm[b*8 +: 8] = {8{m[b]}};
      merged = (ma[wa] & ~bm) | (d & bm);
      for (int p = 0; p < 2; p++) begin
         ra = (p == 0) ? r0 : r1;
         da = ma[ra];
         if (w && wa == ra) da = (ma[ra] & ~bm) | (d & bm);
         db = (ra < 6'd48) ? mb[ra] : 32'h0;
         if (e[p]) begin
            la[p] = da;
            lb[p] = db;
         end
      end
      ea.v = e; ea.d0 = la[0]; ea.d1 = la[1];
      eb.v = e; eb.d0 = lb[0]; eb.d1 = lb[1];
      qa.push_back(ea);
      qb.push_back(eb);
      if (w) begin
         ma[wa] = merged;
         if (wa < 6'd48) mb[wa] = (mb[wa] & ~bm) | (d & bm);
      end
      @(posedge clk);
      #1;
      ga = qa.pop_front();
      gb = qb.pop_front();
      chk("a_valid", val_a, ga.v);
      chk("a_dout", dout_a, {ga.d1, ga.d0});
      chk("b_valid", val_b, gb.v);
      chk("b_dout", dout_b, {gb.d1, gb.d0});
      idle();
   endtask

   // Counts edges after reset release; optionally drives junk traffic early.
   task automatic sweep(input int upto, input bit junk);
      for (int k = 1; k <= upto; k++) begin
         @(posedge clk);
         #1;
         chk("a_ready", rdy_a, (k >= 64));
         chk("b_ready", rdy_b, (k >= 48));
         chk("sweep_valid", {val_b, val_a}, 4'b0);
         if (junk && k == 40) idle();
      end
   endtask

   initial begin
      tbl[0]  = '{1'b1, 6'd5,  32'hDEADBEEF, 4'hF, 2'b00, 6'd0,  6'd0,
                  2'b00, 32'h0, 32'h0};
      tbl[1]  = '{1'b0, 6'd0,  32'h0,        4'h0, 2'b01, 6'd5,  6'd0,
                  2'b01, 32'hDEADBEEF, 32'h0};
      tbl[2]  = '{1'b1, 6'd5,  32'h11223344, 4'h5, 2'b00, 6'd0,  6'd0,
                  2'b00, 32'h0, 32'h0};
      tbl[3]  = '{1'b0, 6'd0,  32'h0,        4'h0, 2'b01, 6'd5,  6'd0,
                  2'b01, 32'hDE22BE44, 32'h0};
      tbl[4]  = '{1'b1, 6'd7,  32'hA5A5A5A5, 4'hF, 2'b11, 6'd7,  6'd7,
                  2'b11, 32'hA5A5A5A5, 32'hA5A5A5A5};
      tbl[5]  = '{1'b0, 6'd0,  32'h0,        4'h0, 2'b11, 6'd7,  6'd5,
                  2'b11, 32'hA5A5A5A5, 32'hDE22BE44};
      tbl[6]  = '{1'b1, 6'd9,  32'h00001234, 4'hF, 2'b00, 6'd0,  6'd0,
                  2'b00, 32'h0, 32'h0};
      tbl[7]  = '{1'b1, 6'd50, 32'hCAFEF00D, 4'hF, 2'b11, 6'd50, 6'd9,
                  2'b11, 32'hCAFEF00D, 32'h00001234};
      tbl[8]  = '{1'b0, 6'd0,  32'h0,        4'h0, 2'b11, 6'd50, 6'd50,
                  2'b11, 32'hCAFEF00D, 32'hCAFEF00D};
      tbl[9]  = '{1'b1, 6'd9,  32'hFFFFFFFF, 4'h0, 2'b01, 6'd9,  6'd0,
                  2'b01, 32'h00001234, 32'h0};
      tbl[10] = '{1'b0, 6'd0,  32'h0,        4'h0, 2'b10, 6'd0,  6'd9,
                  2'b10, 32'h0, 32'h00001234};
      tbl[11] = '{1'b1, 6'd63, 32'h77665544, 4'h8, 2'b11, 6'd63, 6'd62,
                  2'b11, 32'h77000000, 32'h0};

      rst_n = 1'b0;
      idle();
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {rdy_b, rdy_a}, 2'b00);
      chk("rst_valid", {val_b, val_a}, 4'b0);
      chk("rst_dout_a", dout_a, 64'h0);
      chk("rst_dout_b", dout_b, 64'h0);

      // Release reset while hammering writes and reads the sweep must ignore.
      rst_n = 1'b1;
      we    = 1'b1;
      waddr = 6'd3;
      din   = 32'hFFFFFFFF;
      mask  = 4'hF;
      en    = 2'b11;
      raddr = {6'd3, 6'd3};
      chk("ready_k0", {rdy_b, rdy_a}, 2'b00);
      sweep(64, 1'b1);

      for (int a = 0; a < 64; a++) begin
         op(1'b0, 6'd0, 32'h0, 4'h0, 2'b11, 6'(a), 6'(63 - a));
      end

      foreach (tbl[i]) begin
         op(tbl[i].w, tbl[i].wa, tbl[i].d, tbl[i].m,
            tbl[i].e, tbl[i].r0, tbl[i].r1);
         if (tbl[i].xv[0]) chk($sformatf("tbl%0d_p0", i), dout_a[31:0], tbl[i].x0);
         if (tbl[i].xv[1]) chk($sformatf("tbl%0d_p1", i), dout_a[63:32], tbl[i].x1);
      end
      chk("bypass0_b", dout_b[31:0], 32'h0);

      // Reset pulse in RUN, then again at init_cnt=30 of the restarted sweep.
      rst_n = 1'b0;
      #1;
      chk("run_rst_ready", {rdy_b, rdy_a}, 2'b00);
      chk("run_rst_valid", {val_b, val_a}, 4'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_model();
      chk("run_rst_dout", dout_a, 64'h0);
      sweep(30, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", {rdy_b, rdy_a}, 2'b00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sweep(64, 1'b0);

      op(1'b0, 6'd0, 32'h0, 4'h0, 2'b11, 6'd9, 6'd50);
      chk("post_rst_9", dout_a[31:0], 32'h0);
      chk("b_oob_valid", val_b, 2'b11);
      op(1'b0, 6'd0, 32'h0, 4'h0, 2'b11, 6'd3, 6'd7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
